// File: rtl/buffer_entrada_teclado.sv
// Keypad entry buffer: collects decimal key presses into a BCD display buffer and
// hands the committed number to the application over a valid/ack handshake.
module buffer_entrada_teclado #(
   parameter int NUM_DIGITOS    = 4,
   parameter int TIMEOUT_CICLOS = 100000
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [3:0]                         tecla_value,
   input  logic                               tecla_valid,
   output logic [4*NUM_DIGITOS-1:0]           digitos,
   output logic [$clog2(NUM_DIGITOS+1)-1:0]   num_digitos,
   output logic                               entrada_ativa,
   output logic [4*NUM_DIGITOS-1:0]           dado_out,
   output logic                               dado_valid,
   input  logic                               dado_ack,
   output logic                               erro
);

   localparam int W  = 4 * NUM_DIGITOS;
   localparam int NW = $clog2(NUM_DIGITOS + 1);
   localparam int CW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

   localparam logic [NW-1:0] NUM_MAX = NW'(NUM_DIGITOS);
   localparam logic [NW-1:0] NUM_UM  = NW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CICLOS - 1);

   localparam logic [3:0] K_ENTER = 4'hA;
   localparam logic [3:0] K_BACK  = 4'hB;
   localparam logic [3:0] K_CLEAR = 4'hC;

   // Handshake: dado_out is offered while dado_valid=1 and is taken on the
   // first rising edge where dado_ack=1; dado_valid then drops on the next cycle.
   typedef enum logic [1:0] {VAZIO, DIGITANDO, PRONTO} estado_t;

   estado_t         state_q, state_d;
   logic [W-1:0]    dig_q, dig_d;
   logic [NW-1:0]   num_q, num_d;
   logic [W-1:0]    dado_q, dado_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            erro_q, erro_d;
   logic            e_digito;

   assign e_digito = (tecla_value <= 4'd9);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= VAZIO;
         dig_q   <= '0;
         num_q   <= '0;
         dado_q  <= '0;
         cnt_q   <= '0;
         erro_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         num_q   <= num_d;
         dado_q  <= dado_d;
         cnt_q   <= cnt_d;
         erro_q  <= erro_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      num_d   = num_q;
      dado_d  = dado_q;
      cnt_d   = '0;
      erro_d  = 1'b0;
      case (state_q)
         VAZIO: begin
            if (tecla_valid) begin
               if (e_digito) begin
                  dig_d   = {{(W-4){1'b0}}, tecla_value};
                  num_d   = NUM_UM;
                  state_d = DIGITANDO;
               end else if (tecla_value == K_ENTER) begin
                  erro_d = 1'b1;
               end
            end
         end
         DIGITANDO: begin
            if (tecla_valid) begin
               if (e_digito) begin
                  if (num_q < NUM_MAX) begin
                     dig_d = {dig_q[W-5:0], tecla_value};
                     num_d = num_q + NUM_UM;
                  end else begin
                     erro_d = 1'b1;
                  end
               end else if (tecla_value == K_ENTER) begin
                  dado_d  = dig_q;
                  dig_d   = '0;
                  num_d   = '0;
                  state_d = PRONTO;
               end else if (tecla_value == K_BACK) begin
                  dig_d = {4'h0, dig_q[W-1:4]};
                  num_d = num_q - NUM_UM;
                  if (num_q == NUM_UM) state_d = VAZIO;
               end else if (tecla_value == K_CLEAR) begin
                  dig_d   = '0;
                  num_d   = '0;
                  state_d = VAZIO;
               end
            end else if (cnt_q == CNT_MAX) begin
               // Idle too long: abandon the partial entry.
               dig_d   = '0;
               num_d   = '0;
               erro_d  = 1'b1;
               state_d = VAZIO;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRONTO: begin
            if (tecla_valid && tecla_value <= K_CLEAR) erro_d = 1'b1;
            if (dado_ack) state_d = VAZIO;
         end
         default: state_d = VAZIO;
      endcase
   end

   assign digitos       = dig_q;
   assign num_digitos   = num_q;
   assign entrada_ativa = (state_q == DIGITANDO);
   assign dado_out      = dado_q;
   assign dado_valid    = (state_q == PRONTO);
   assign erro          = erro_q;

endmodule
